// File: rtl/apu_frame_counter.sv
// APU frame sequencer: 4-step / 5-step quarter- and half-frame strobes plus frame IRQ.
// Define APU_FRAME_IRQ_EN to build the IRQ flag, irq_inhibit and the $4015-read clear.
module apu_frame_counter #(
    parameter int CNT_WIDTH = 16,
    parameter int WR_DELAY  = 3
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       clk_en,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       status_rd,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode
);

    localparam logic [CNT_WIDTH-1:0] STEP_Q1    = CNT_WIDTH'(7457);
    localparam logic [CNT_WIDTH-1:0] STEP_H1    = CNT_WIDTH'(14913);
    localparam logic [CNT_WIDTH-1:0] STEP_Q3    = CNT_WIDTH'(22371);
    localparam logic [CNT_WIDTH-1:0] STEP_IRQ   = CNT_WIDTH'(29828);
    localparam logic [CNT_WIDTH-1:0] LAST_4STEP = CNT_WIDTH'(29829);
    localparam logic [CNT_WIDTH-1:0] LAST_5STEP = CNT_WIDTH'(37281);
    localparam logic [2:0]           DELAY_LOAD = 3'(WR_DELAY);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] last_cnt;
    logic [2:0]           delay_q, delay_d;
    logic                 pend_mode_q, pend_mode_d;
    logic                 mode_q, mode_d;
    logic                 qf_q, qf_d;
    logic                 hf_q, hf_d;
    logic                 apply;
    logic                 step_qf, step_hf, step_irq;
    logic                 irq_set;

    // A non-zero delay counter means a $4017 write is pending.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        delay_d     = delay_q;
        pend_mode_d = pend_mode_q;
        apply       = 1'b0;
        if (wr_en) begin
            delay_d     = DELAY_LOAD;
            pend_mode_d = wr_data[7];
        end else if (clk_en && (delay_q != 3'd0)) begin
            delay_d = delay_q - 3'd1;
            apply   = (delay_q == 3'd1);
        end
    end

    assign last_cnt = mode_q ? LAST_5STEP : LAST_4STEP;

    always_comb begin
        step_qf  = (cnt_q == STEP_Q1) || (cnt_q == STEP_H1) ||
                   (cnt_q == STEP_Q3) || (cnt_q == last_cnt);
        step_hf  = (cnt_q == STEP_H1) || (cnt_q == last_cnt);
        step_irq = !mode_q && ((cnt_q == STEP_IRQ) || (cnt_q == LAST_4STEP));
    end

    // The write-apply tick forces the count to 0 and masks any step match in that tick.
    always_comb begin
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        qf_d    = 1'b0;
        hf_d    = 1'b0;
        irq_set = 1'b0;
        if (clk_en) begin
            if (apply) begin
                cnt_d  = '0;
                mode_d = pend_mode_q;
                qf_d   = pend_mode_q;
                hf_d   = pend_mode_q;
            end else begin
                qf_d    = step_qf;
                hf_d    = step_hf;
                irq_set = step_irq;
                cnt_d   = (cnt_q == last_cnt) ? '0 : cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt_q       <= '0;
            delay_q     <= 3'd0;
            pend_mode_q <= 1'b0;
            mode_q      <= 1'b0;
            qf_q        <= 1'b0;
            hf_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            delay_q     <= delay_d;
            pend_mode_q <= pend_mode_d;
            mode_q      <= mode_d;
            qf_q        <= qf_d;
            hf_q        <= hf_d;
        end
    end

    assign quarter_frame = qf_q;
    assign half_frame    = hf_q;
    assign mode          = mode_q;

`ifdef APU_FRAME_IRQ_EN
    logic irq_q, irq_d;
    logic inhibit_q, inhibit_d;
    logic unused_wr_bits;

    // A set uses the inhibit value from before this clk's write; set beats any clear.
    always_comb begin
        inhibit_d = wr_en ? wr_data[6] : inhibit_q;
        irq_d     = irq_q;
        if (irq_set && !inhibit_q) begin
            irq_d = 1'b1;
        end else if (status_rd || (wr_en && wr_data[6])) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            irq_q     <= 1'b0;
            inhibit_q <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            inhibit_q <= inhibit_d;
        end
    end

    assign frame_irq      = irq_q;
    assign unused_wr_bits = ^wr_data[5:0];
`else
    logic unused_irq_inputs;

    assign frame_irq         = 1'b0;
    assign unused_irq_inputs = ^{wr_data[6:0], status_rd, irq_set};
`endif

endmodule

// File: tb/tb_apu_frame_counter.sv
// Scoreboard bench for apu_frame_counter: a tick-level reference model pushes expected
// outputs per clk; a monitor pops and compares on the opposite clock edge.
module tb_apu_frame_counter;

    localparam int CNT_WIDTH = 16;
    localparam int WR_DELAY  = 3;
    localparam int MAX_ERR   = 40;
`ifdef APU_FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic qf;
        logic hf;
        logic irq;
        logic mode;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       clk_en;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       status_rd;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode;

    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";
    exp_t  sb_q[$];

    apu_frame_counter #(
        .CNT_WIDTH(CNT_WIDTH),
        .WR_DELAY (WR_DELAY)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .clk_en       (clk_en),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .status_rd    (status_rd),
        .quarter_frame(quarter_frame),
        .half_frame   (half_frame),
        .frame_irq    (frame_irq),
        .mode         (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s phase=%s got=%b want=%b t=%0t", name, phase, act, exp, $time);
        end
    endtask

    // Reference model: the step table and write rules in plain integer form.
    function automatic int period(input bit m);
        return m ? 37282 : 29830;
    endfunction

    function automatic bit is_full_step(input bit m, input int c);
        return c == period(m) - 1;
    endfunction

    function automatic bit is_qf(input bit m, input int c);
        return (c == 7457) || (c == 14913) || (c == 22371) || is_full_step(m, c);
    endfunction

    function automatic bit is_hf(input bit m, input int c);
        return (c == 14913) || is_full_step(m, c);
    endfunction

    int m_count;
    int m_pend;
    bit m_mode, m_pmode, m_inh, m_irq;

    always @(posedge clk) begin : model_step
        bit   qf, hf, set_irq, clr_irq, forced;
        exp_t e;
        qf      = 1'b0;
        hf      = 1'b0;
        set_irq = 1'b0;
        forced  = 1'b0;
        if (!rst_l) begin
            m_count = 0;
            m_pend  = 0;
            m_mode  = 1'b0;
            m_pmode = 1'b0;
            m_inh   = 1'b0;
            m_irq   = 1'b0;
        end else begin
            clr_irq = status_rd || (wr_en && wr_data[6]);
            if (clk_en && !wr_en && m_pend > 0) begin
                m_pend--;
                forced = (m_pend == 0);
            end
            if (clk_en) begin
                if (forced) begin
                    m_count = 0;
                    m_mode  = m_pmode;
                    qf      = m_mode;
                    hf      = m_mode;
                end else begin
                    qf      = is_qf(m_mode, m_count);
                    hf      = is_hf(m_mode, m_count);
                    set_irq = !m_mode && (m_count == 29828 || m_count == 29829) && !m_inh;
                    m_count = (m_count + 1) % period(m_mode);
                end
            end
            if (IRQ_EN) begin
                if (set_irq)      m_irq = 1'b1;
                else if (clr_irq) m_irq = 1'b0;
            end
            if (wr_en) begin
                m_pend  = WR_DELAY;
                m_pmode = wr_data[7];
                m_inh   = wr_data[6];
            end
        end
        e = '{qf, hf, m_irq, m_mode};
        sb_q.push_back(e);
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("outputs{qf,hf,irq,mode}", {quarter_frame, half_frame, frame_irq, mode},
                      {e.qf, e.hf, e.irq, e.mode});
                if (half_frame) check("hf_without_qf", {3'b0, quarter_frame}, 4'b0001);
            end
        end
    end

    task automatic drive(input bit rst, input bit en, input bit wr, input logic [7:0] d, input bit rd);
        @(negedge clk);
        rst_l     = rst;
        clk_en    = en;
        wr_en     = wr;
        wr_data   = d;
        status_rd = rd;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n && errors < MAX_ERR; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin : stimulus
        rst_l     = 1'b0;
        clk_en    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        status_rd = 1'b0;
        repeat (3) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        phase = "four_step";
        ticks(29829);
        phase = "irq_clear";
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        phase = "irq_set_wins";
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        phase = "write_40";
        drive(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
        ticks(3);

        phase = "five_step";
        drive(1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
        ticks(37285);

        phase = "cancel";
        drive(1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
        ticks(2);
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        ticks(10);

        phase = "random";
        for (int i = 0; i < 3000 && errors < MAX_ERR; i++)
            drive(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                  8'($urandom), ($urandom_range(0, 19) == 0));

        phase = "reset_pending";
        for (int i = 0; i < 12; i++) drive(1'b1, (i % 3 == 0), (i == 1), 8'h80, 1'b0);
        for (int i = 0; i < 6; i++)  drive(1'b0, (i % 3 == 0), 1'b0, 8'h00, 1'b0);
        phase = "after_reset";
        for (int i = 0; i < 9; i++)  drive(1'b1, (i % 3 == 0), 1'b0, 8'h00, 1'b0);
        ticks(7460);

        phase = "drain";
        repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
